// File: rtl/compare_seq.sv
// Multi-cycle magnitude comparator: walks operands MSB-chunk first, DIGIT bits per cycle,
// exiting on the first differing chunk and falling back to a one-hot cascade input.
module compare_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic             iSigned,
    input  logic [WIDTH-1:0] iData_a,
    input  logic [WIDTH-1:0] iData_b,
    input  logic [2:0]       iData,
    output logic             oReady,
    output logic             oDone,
    output logic [2:0]       oData
);
    localparam int unsigned NCHUNK = WIDTH / DIGIT;
    localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [2:0]        casc_q, casc_d;
    logic              signed_q, signed_d;
    logic [KW-1:0]     k_q, k_d;
    logic [2:0]        data_q, data_d;

    logic [DIGIT-1:0]  a_chunk, b_chunk;
    logic [2:0]        casc_res;
    logic              accept;

    assign oReady = (state_q == StIdle) || (state_q == StDone);
    assign oDone  = (state_q == StDone);
    assign oData  = data_q;
    assign accept = iStart && oReady;

    // Select the current chunk; in signed mode the top chunk gets its MSB flipped so that
    // an unsigned compare yields two's-complement ordering.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (k_q == KW'(i)) begin
                a_chunk = a_q[i*DIGIT +: DIGIT];
                b_chunk = b_q[i*DIGIT +: DIGIT];
            end
        end
        if (signed_q && (k_q == KW'(NCHUNK - 1))) begin
            a_chunk[DIGIT-1] = ~a_chunk[DIGIT-1];
            b_chunk[DIGIT-1] = ~b_chunk[DIGIT-1];
        end
    end

    // Priority keeps the result one-hot even for malformed cascade inputs.
    always_comb begin
        if (casc_q[2])      casc_res = 3'b100;
        else if (casc_q[1]) casc_res = 3'b010;
        else                casc_res = 3'b001;
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        casc_d   = casc_q;
        signed_d = signed_q;
        k_d      = k_q;
        data_d   = data_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (accept) begin
                    state_d  = StRun;
                    a_d      = iData_a;
                    b_d      = iData_b;
                    casc_d   = iData;
                    signed_d = iSigned;
                    k_d      = KW'(NCHUNK - 1);
                end
            end
            StRun: begin
                if (a_chunk > b_chunk) begin
                    data_d  = 3'b100;
                    state_d = StDone;
                end else if (a_chunk < b_chunk) begin
                    data_d  = 3'b010;
                    state_d = StDone;
                end else if (k_q != '0) begin
                    k_d = k_q - 1'b1;
                end else begin
                    data_d  = casc_res;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            casc_q   <= '0;
            signed_q <= 1'b0;
            k_q      <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            casc_q   <= casc_d;
            signed_q <= signed_d;
            k_q      <= k_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: tb/tb_compare_seq.sv
// Directed bench for compare_seq: vector table of compares plus reset-abort and handshake
// sequences.
module tb_compare_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sgn;
    logic [15:0] a, b;
    logic [2:0]  casc;
    logic        ready, done;
    logic [2:0]  data;

    int checks = 0;
    int errors = 0;

    compare_seq #(.WIDTH(16), .DIGIT(4)) dut (
        .iClk    (clk),
        .iRst    (rst),
        .iStart  (start),
        .iSigned (sgn),
        .iData_a (a),
        .iData_b (b),
        .iData   (casc),
        .oReady  (ready),
        .oDone   (done),
        .oData   (data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  casc;
        logic [2:0]  exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Counts edges after the accept edge until oDone is seen; 99 if it never arrives.
    task automatic wait_done(output logic [2:0] res, output int lat);
        int n;
        logic seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (done) seen = 1'b1;
        end
        lat = seen ? n : 99;
        res = data;
    endtask

    // Drives one request at the next negedge; returns right after the accept edge.
    task automatic issue(input logic s, input logic [15:0] va, input logic [15:0] vb,
                         input logic [2:0] vc);
        @(negedge clk);
        start = 1'b1;
        sgn   = s;
        a     = va;
        b     = vb;
        casc  = vc;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~va;
        b     = vb ^ 16'h5a5a;
        casc  = 3'b110;
        sgn   = ~s;
    endtask

    logic [2:0] res;
    int         lat;
    int         pulses;

    initial begin
        vecs[0]  = '{1'b0, 16'h1234, 16'h1234, 3'b000, 3'b001, 4};
        vecs[1]  = '{1'b0, 16'h8000, 16'h7fff, 3'b000, 3'b100, 1};
        vecs[2]  = '{1'b1, 16'h8000, 16'h7fff, 3'b000, 3'b010, 1};
        vecs[3]  = '{1'b1, 16'hffff, 16'hfffe, 3'b000, 3'b100, 4};
        vecs[4]  = '{1'b0, 16'h1334, 16'h1234, 3'b000, 3'b100, 2};
        vecs[5]  = '{1'b0, 16'h1234, 16'h1235, 3'b000, 3'b010, 4};
        vecs[6]  = '{1'b0, 16'h00f0, 16'h00f0, 3'b100, 3'b100, 4};
        vecs[7]  = '{1'b0, 16'h00f0, 16'h00f0, 3'b010, 3'b010, 4};
        vecs[8]  = '{1'b0, 16'h00f0, 16'h00f0, 3'b110, 3'b100, 4};
        vecs[9]  = '{1'b0, 16'h00f0, 16'h00f0, 3'b001, 3'b001, 4};
        vecs[10] = '{1'b1, 16'h0001, 16'hffff, 3'b000, 3'b100, 1};
        vecs[11] = '{1'b0, 16'h0120, 16'h0130, 3'b011, 3'b010, 3};

        rst = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0; casc = '0;
        #12;
        check("reset_ready", int'(ready), 1);
        check("reset_done", int'(done), 0);
        check("reset_data", int'(data), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].casc);
            check($sformatf("vec%0d_busy", i), int'(ready), 0);
            wait_done(res, lat);
            check($sformatf("vec%0d_data", i), int'(res), int'(vecs[i].exp_data));
            check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
        end

        // Reset two cycles into a compare aborts it silently.
        issue(1'b0, 16'h5555, 16'h5555, 3'b000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_not_done", int'(done), 0);
        rst = 1'b1;
        #1;
        check("abort_data", int'(data), 0);
        check("abort_ready", int'(ready), 1);
        check("abort_done", int'(done), 0);
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check("abort_no_pulse", pulses, 0);
        check("abort_idle_ready", int'(ready), 1);
        issue(1'b0, 16'h5555, 16'h5555, 3'b000);
        wait_done(res, lat);
        check("after_abort_data", int'(res), 1);
        check("after_abort_lat", lat, 4);

        // Start held during RUN with different operands must be ignored.
        issue(1'b0, 16'h0010, 16'h0020, 3'b000);
        start = 1'b1; a = 16'hf000; b = 16'h0000; casc = 3'b100;
        @(posedge clk); #1;
        check("hold_busy", int'(ready), 0);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        begin
            logic [2:0] r2;
            int l2;
            wait_done(r2, l2);
            res = r2;
            lat = (l2 == 99) ? 99 : l2 + 1;
        end
        check("hold_data", int'(res), 3'b010);
        check("hold_lat", lat, 3);

        // Back-to-back: start accepted during the DONE cycle.
        check("b2b_ready_in_done", int'(ready), 1);
        start = 1'b1; sgn = 1'b0; a = 16'h0001; b = 16'h0002; casc = 3'b000;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_accepted", int'(ready), 0);
        wait_done(res, lat);
        check("b2b_data", int'(res), 3'b010);
        check("b2b_lat", lat, 4);
        @(posedge clk); #1;
        check("b2b_single_pulse", int'(done), 0);
        check("b2b_data_held", int'(data), 3'b010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
